mem_stage: RTL and testbench

Memory (M) stage of the 5-stage RV32I pipeline. Consumes the registered execute-stage bundle (lib_pkg::bus_stage_e) and performs the data-memory access over a variable-latency req/ack port. It produces the registered writeback bundle (lib_pkg::bus_stage_m). The stage stalls upstream while an access is outstanding, handles byte-lane alignment and load extension, and suppresses misaligned accesses.

---
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Purpose: RV32I memory stage; performs the data-memory access and registers the writeback bundle.
// Latency: 1 cycle for non-memory ops and zero-wait accesses; N extra stall cycles for an N-cycle ack.
// Backpressure: m_stall holds upstream while a request is outstanding; a bubble is sent downstream meanwhile.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   e_bus, e_valid        execute-stage bundle and its live flag (bundle held stable while m_stall=1)
//   m_stall               combinational stall to upstream stages
//   dmem_req/we/addr/wdata data-memory request (held until dmem_ack), lane-shifted enables and data
//   dmem_ack, dmem_rdata  one-cycle completion pulse with read data in the same cycle
//   m_bus, m_valid        registered writeback bundle and its live flag
//   misalign              registered pulse for a suppressed misaligned access

package lib_pkg;

    // 112 bits
    typedef struct packed {
        logic [31:0] inc_pc;
        logic [31:0] ex_out;
        logic [31:0] rf_rdata2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  dmem_wr_en;
        logic        sel_res;    // 1 = result comes from a load
        logic        sel_rf_wr;
        logic        rf_wr_en;
        logic        ecall;
    } bus_stage_e;

    // 72 bits
    typedef struct packed {
        logic [31:0] inc_pc;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        sel_rf_wr;
        logic        rf_wr_en;
        logic        ecall;
    } bus_stage_m;

endpackage

module mem_stage
    import lib_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  bus_stage_e        e_bus,
    input  logic              e_valid,
    output logic              m_stall,
    output logic              dmem_req,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output bus_stage_m        m_bus,
    output logic              m_valid,
    output logic              misalign
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [1:0]  off;
    logic        is_store, is_load, memop;
    logic        acc_half, acc_word;
    logic        misaligned, aligned_op;
    logic [31:0] rd_shifted;
    logic [31:0] ld_data;

    assign off = e_bus.ex_out[1:0];

    // A store wins when both the load select and a write enable are set.
    assign is_store = e_valid & (|e_bus.dmem_wr_en);
    assign is_load  = e_valid & e_bus.sel_res & ~is_store;
    assign memop    = is_store | is_load;

    // Load size: funct3[1:0] 00 byte, 01 half, anything else word.
    always_comb begin
        acc_half = 1'b0;
        acc_word = 1'b0;
        if (is_store) begin
            acc_half = (e_bus.dmem_wr_en == 4'b0011);
            acc_word = (e_bus.dmem_wr_en == 4'b1111);
        end else begin
            acc_half = (e_bus.funct3[1:0] == 2'b01);
            acc_word = e_bus.funct3[1];
        end
    end

    assign misaligned = memop & ((acc_half & (off == 2'd3)) | (acc_word & (off != 2'd0)));
    assign aligned_op = memop & ~misaligned;

    assign dmem_addr  = {e_bus.ex_out[ADDR_W-1:2], 2'b00};
    assign dmem_we    = is_store ? (e_bus.dmem_wr_en << off) : 4'b0000;
    assign dmem_wdata = e_bus.rf_rdata2 << {off, 3'b000};

    assign rd_shifted = dmem_rdata >> {off, 3'b000};

    always_comb begin
        ld_data = rd_shifted;
        case (e_bus.funct3)
            3'b000:  ld_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  ld_data = {24'h0, rd_shifted[7:0]};
            3'b001:  ld_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  ld_data = {16'h0, rd_shifted[15:0]};
            default: ld_data = rd_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        case (state)
            IDLE: begin
                dmem_req = aligned_op;
                // A zero-wait ack completes in place; an ack with no request is ignored.
                if (aligned_op && !dmem_ack) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset abandons the access at once, even if the bundle still shows a memory op.
        if (!rst_n) begin
            dmem_req = 1'b0;
        end
    end

    assign m_stall = dmem_req & ~dmem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bus    <= '0;
            m_valid  <= 1'b0;
            misalign <= 1'b0;
        end else if (!m_stall) begin
            m_valid          <= e_valid;
            m_bus.rd         <= e_bus.rd;
            m_bus.sel_rf_wr  <= e_bus.sel_rf_wr;
            m_bus.inc_pc     <= e_bus.inc_pc;
            m_bus.result     <= is_load ? ld_data : e_bus.ex_out;
            m_bus.rf_wr_en   <= e_valid & e_bus.rf_wr_en & ~misaligned;
            m_bus.ecall      <= e_valid & e_bus.ecall;
            misalign         <= misaligned;
        end else begin
            // m_bus holds; the bubble keeps writeback from seeing the same retire twice.
            m_valid  <= 1'b0;
            misalign <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, loads of each size with varying ack latency,
// store lane shifting, misaligned suppression, bubbles and reset during an outstanding access.
module tb_mem_stage;
    import lib_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    bus_stage_e  e_bus;
    logic        e_valid;
    logic        m_stall;
    logic        dmem_req;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    bus_stage_m  m_bus;
    logic        m_valid;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .e_bus      (e_bus),
        .e_valid    (e_valid),
        .m_stall    (m_stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .m_bus      (m_bus),
        .m_valid    (m_valid),
        .misalign   (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic [31:0] ex, input logic [31:0] d2, input logic sel,
                         input logic [3:0] we, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rfw);
        e_bus            = '0;
        e_bus.ex_out     = ex;
        e_bus.rf_rdata2  = d2;
        e_bus.sel_res    = sel;
        e_bus.dmem_wr_en = we;
        e_bus.funct3     = f3;
        e_bus.rd         = rd;
        e_bus.rf_wr_en   = rfw;
        e_bus.inc_pc     = ex + 32'd4;
        e_valid          = 1'b1;
        dmem_ack         = 1'b0;
    endtask

    // Load with n stall cycles before the ack (n=0 is a zero-wait access).
    task automatic load_wait(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input int n, input logic [31:0] word, input logic [31:0] exp);
        @(negedge clk);
        set_e(addr, 32'h0, 1'b1, 4'b0000, f3, 5'd9, 1'b1);
        dmem_ack   = (n == 0);
        dmem_rdata = word;
        #1;
        chk({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
        chk({tag, "_we"}, {28'b0, dmem_we}, 32'h0);
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        for (int i = 0; i < n; i++) begin
            chk({tag, "_stall_hi"}, {31'b0, m_stall}, 32'd1);
            tick();
            chk({tag, "_mvalid_stall"}, {31'b0, m_valid}, 32'd0);
            @(negedge clk);
            if (i == n - 1) dmem_ack = 1'b1;
            #1;
        end
        chk({tag, "_stall_lo"}, {31'b0, m_stall}, 32'd0);
        tick();
        chk({tag, "_result"}, m_bus.result, exp);
        chk({tag, "_mvalid"}, {31'b0, m_valid}, 32'd1);
        chk({tag, "_rfwe"}, {31'b0, m_bus.rf_wr_en}, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        e_valid    = 1'b0;
        e_bus      = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #2;
        chk("rst_mvalid", {31'b0, m_valid}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_result", m_bus.result, 32'h0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU passthrough with ecall
        set_e(32'h1234_5678, 32'h0, 1'b0, 4'b0000, 3'b010, 5'd5, 1'b1);
        e_bus.ecall = 1'b1;
        #1;
        chk("alu_req", {31'b0, dmem_req}, 32'd0);
        chk("alu_stall", {31'b0, m_stall}, 32'd0);
        tick();
        chk("alu_mvalid", {31'b0, m_valid}, 32'd1);
        chk("alu_result", m_bus.result, 32'h1234_5678);
        chk("alu_rd", {27'b0, m_bus.rd}, 32'd5);
        chk("alu_rfwe", {31'b0, m_bus.rf_wr_en}, 32'd1);
        chk("alu_ecall", {31'b0, m_bus.ecall}, 32'd1);
        chk("alu_incpc", m_bus.inc_pc, 32'h1234_567C);

        load_wait("lw0", 32'h100, 3'b010, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_wait("lb3", 32'h203, 3'b000, 3, 32'h8012_3456, 32'hFFFF_FF80);
        load_wait("lbu3", 32'h203, 3'b100, 3, 32'h8012_3456, 32'h0000_0080);
        load_wait("lh1", 32'h102, 3'b001, 1, 32'h8001_0000, 32'hFFFF_8001);
        load_wait("lhu0", 32'h102, 3'b101, 0, 32'h8001_0000, 32'h0000_8001);

        // SH at 0x42
        @(negedge clk);
        set_e(32'h42, 32'h0000_ABCD, 1'b0, 4'b0011, 3'b001, 5'd0, 1'b0);
        dmem_ack = 1'b1;
        #1;
        chk("sh_req", {31'b0, dmem_req}, 32'd1);
        chk("sh_addr", dmem_addr, 32'h40);
        chk("sh_we", {28'b0, dmem_we}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD_0000);
        chk("sh_stall", {31'b0, m_stall}, 32'd0);
        tick();
        chk("sh_mvalid", {31'b0, m_valid}, 32'd1);

        // Misaligned LW
        @(negedge clk);
        set_e(32'h102, 32'h0, 1'b1, 4'b0000, 3'b010, 5'd7, 1'b1);
        #1;
        chk("mlw_req", {31'b0, dmem_req}, 32'd0);
        chk("mlw_stall", {31'b0, m_stall}, 32'd0);
        tick();
        chk("mlw_mvalid", {31'b0, m_valid}, 32'd1);
        chk("mlw_misalign", {31'b0, misalign}, 32'd1);
        chk("mlw_rfwe", {31'b0, m_bus.rf_wr_en}, 32'd0);
        chk("mlw_rd", {27'b0, m_bus.rd}, 32'd7);

        // Misaligned SW
        @(negedge clk);
        set_e(32'h101, 32'h5555_AAAA, 1'b0, 4'b1111, 3'b010, 5'd0, 1'b0);
        #1;
        chk("msw_req", {31'b0, dmem_req}, 32'd0);
        tick();
        chk("msw_mvalid", {31'b0, m_valid}, 32'd1);
        chk("msw_misalign", {31'b0, misalign}, 32'd1);

        // Bubble
        @(negedge clk);
        set_e(32'h300, 32'h0, 1'b1, 4'b0000, 3'b010, 5'd4, 1'b1);
        e_bus.ecall = 1'b1;
        e_valid     = 1'b0;
        #1;
        chk("bub_req", {31'b0, dmem_req}, 32'd0);
        tick();
        chk("bub_mvalid", {31'b0, m_valid}, 32'd0);
        chk("bub_misalign", {31'b0, misalign}, 32'd0);
        chk("bub_rfwe", {31'b0, m_bus.rf_wr_en}, 32'd0);
        chk("bub_ecall", {31'b0, m_bus.ecall}, 32'd0);

        // Reset while waiting on an ack
        @(negedge clk);
        set_e(32'h300, 32'h0, 1'b1, 4'b0000, 3'b010, 5'd4, 1'b1);
        tick();
        chk("rwait_req", {31'b0, dmem_req}, 32'd1);
        chk("rwait_stall", {31'b0, m_stall}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_req", {31'b0, dmem_req}, 32'd0);
        chk("rmid_stall", {31'b0, m_stall}, 32'd0);
        chk("rmid_mvalid", {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        e_valid  = 1'b0;
        dmem_ack = 1'b1;
        #1;
        chk("stale_req", {31'b0, dmem_req}, 32'd0);
        chk("stale_stall", {31'b0, m_stall}, 32'd0);
        tick();
        chk("stale_mvalid", {31'b0, m_valid}, 32'd0);

        load_wait("lwpost", 32'h304, 3'b010, 1, 32'h1122_3344, 32'h1122_3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
